// File: rtl/jedro_1_mem_arbiter.sv
// ---------------------------------------------------------------------------
// jedro_1_mem_arbiter
//
// Shares one single-port synchronous RAM between the jedro_1 instruction
// fetch port (i_*) and the load/store port (d_*).
//
// At most one requester is granted per cycle. Data wins ties unless the
// fetch side has been refused STARVE_MAX cycles in a row. Every grant pushes
// a {valid, src, err} tag into a RAM_LATENCY-deep pipeline, so the tag
// reaches the output in the same cycle as the RAM data for that access.
// Responses come back in grant order and cannot be stalled.
//
// Handshake: a request is accepted in the cycle where *_req_i and *_gnt_o
// are both 1. Its response (*_rvalid_o, with *_rdata_o and *_err_o) is
// shown for exactly one cycle, RAM_LATENCY cycles after the grant cycle.
// The requester must take it in that cycle.
//
// Ports:
//   clk_i, rstn_i           clock (rising edge), async active-low reset
//   i_req_i/i_addr_i        fetch request and byte address
//   i_gnt_o                 fetch accepted this cycle
//   i_rvalid_o/i_rdata_o/i_err_o   fetch response
//   d_req_i/d_we_i/d_be_i/d_addr_i/d_wdata_i   load/store request
//   d_gnt_o                 data accepted this cycle
//   d_rvalid_o/d_rdata_o/d_err_o   load data or store acknowledge
//   ram_en_o/ram_we_o/ram_addr_o/ram_wdata_o/ram_rdata_i   RAM port
// ---------------------------------------------------------------------------
module jedro_1_mem_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int RAM_AW      = 12,
    parameter int RAM_LATENCY = 1,
    parameter int STARVE_MAX  = 3
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    // instruction fetch port
    input  logic                  i_req_i,
    input  logic [DATA_WIDTH-1:0] i_addr_i,
    output logic                  i_gnt_o,
    output logic                  i_rvalid_o,
    output logic [DATA_WIDTH-1:0] i_rdata_o,
    output logic                  i_err_o,
    // data port
    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [3:0]            d_be_i,
    input  logic [DATA_WIDTH-1:0] d_addr_i,
    input  logic [DATA_WIDTH-1:0] d_wdata_i,
    output logic                  d_gnt_o,
    output logic                  d_rvalid_o,
    output logic [DATA_WIDTH-1:0] d_rdata_o,
    output logic                  d_err_o,
    // RAM port
    output logic                  ram_en_o,
    output logic [3:0]            ram_we_o,
    output logic [RAM_AW-1:0]     ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_wdata_o,
    input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic valid;
        logic src_d;   // 1 = data port, 0 = fetch port
        logic err;
    } tag_t;

    logic [SW-1:0]   r_starve_cnt;
    tag_t            r_tag [RAM_LATENCY];

    logic            w_starved;
    logic            w_sel_i;
    logic            w_sel_d;
    logic            w_gnt_any;
    logic            w_i_err;
    logic            w_d_err;
    logic            w_err;
    logic [RAM_AW-1:0] w_word_addr;
    tag_t            w_tag_out;
    logic [DATA_WIDTH-1:0] w_rsp_data;
    logic            w_unused;

    // Byte offset of data accesses has no meaning here; the LSU encodes the
    // lanes in d_be_i.
    assign w_unused = ^d_addr_i[1:0];

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign w_starved = (r_starve_cnt == SW'(STARVE_MAX));
    assign w_sel_i   = i_req_i && (!d_req_i || w_starved);
    assign w_sel_d   = d_req_i && !w_sel_i;

    // Grants are masked while reset is held so nothing reaches the RAM.
    assign i_gnt_o   = rstn_i && w_sel_i;
    assign d_gnt_o   = rstn_i && w_sel_d;
    assign w_gnt_any = i_gnt_o || d_gnt_o;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign w_i_err = (|i_addr_i[DATA_WIDTH-1:RAM_AW+2]) || (|i_addr_i[1:0]);
    assign w_d_err = |d_addr_i[DATA_WIDTH-1:RAM_AW+2];
    assign w_err   = i_gnt_o ? w_i_err : w_d_err;
    assign w_word_addr = i_gnt_o ? i_addr_i[RAM_AW+1:2] : d_addr_i[RAM_AW+1:2];

    // ------------------------------------------------------------------
    // RAM request
    // ------------------------------------------------------------------
    always_comb begin
        ram_en_o    = 1'b0;
        ram_we_o    = 4'b0000;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        // A granted access that fails decode still gets a response, but
        // never touches the RAM.
        if (w_gnt_any && !w_err) begin
            ram_en_o   = 1'b1;
            ram_addr_o = w_word_addr;
            if (d_gnt_o && d_we_i) begin
                ram_we_o    = d_be_i;
                ram_wdata_o = d_wdata_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Starvation counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_starve_cnt <= '0;
        end else if (i_req_i && !i_gnt_o) begin
            if (!w_starved) begin
                r_starve_cnt <= r_starve_cnt + SW'(1);
            end
        end else begin
            r_starve_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Tag pipeline (depth matches RAM read latency)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int k = 0; k < RAM_LATENCY; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            r_tag[0] <= '{valid: w_gnt_any, src_d: d_gnt_o, err: w_err};
            for (int k = 1; k < RAM_LATENCY; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Response routing
    // ------------------------------------------------------------------
    assign w_tag_out  = r_tag[RAM_LATENCY-1];
    // The RAM output is stale for error accesses, so it is not forwarded.
    assign w_rsp_data = w_tag_out.err ? '0 : ram_rdata_i;

    assign i_rvalid_o = w_tag_out.valid && !w_tag_out.src_d;
    assign d_rvalid_o = w_tag_out.valid &&  w_tag_out.src_d;
    assign i_err_o    = i_rvalid_o && w_tag_out.err;
    assign d_err_o    = d_rvalid_o && w_tag_out.err;
    assign i_rdata_o  = i_rvalid_o ? w_rsp_data : '0;
    assign d_rdata_o  = d_rvalid_o ? w_rsp_data : '0;

endmodule

// File: tb/tb_jedro_1_mem_arbiter.sv
module tb_jedro_1_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int EW = 51;  // {chk_data, src_d, err, data[31:0], due_cycle[15:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn;
  logic init_mem;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- DUT 1 (RAM_LATENCY = 1) ----------------
  logic          i_req, i_gnt, i_rvalid, i_err;
  logic [DW-1:0] i_addr, i_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [3:0]    d_be;
  logic [DW-1:0] d_addr, d_wdata, d_rdata;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  jedro_1_mem_arbiter #(.DATA_WIDTH(DW), .RAM_AW(AW), .RAM_LATENCY(1), .STARVE_MAX(3)) u_dut (
    .clk_i(clk), .rstn_i(rstn),
    .i_req_i(i_req), .i_addr_i(i_addr), .i_gnt_o(i_gnt),
    .i_rvalid_o(i_rvalid), .i_rdata_o(i_rdata), .i_err_o(i_err),
    .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata), .d_err_o(d_err),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  logic [DW-1:0] mem1 [4096];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 4096; i++) mem1[i] <= '0;
      mem1[4]    <= 32'hDEAD_BEEF;
      mem1[4095] <= 32'hA5A5_0FF0;
    end else if (ram_en) begin
      ram_rdata <= mem1[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem1[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  // ---------------- DUT 2 (RAM_LATENCY = 2) ----------------
  logic          i_req2, i_gnt2, i_rvalid2, i_err2;
  logic [DW-1:0] i_addr2, i_rdata2;
  logic          d_req2, d_we2, d_gnt2, d_rvalid2, d_err2;
  logic [3:0]    d_be2;
  logic [DW-1:0] d_addr2, d_wdata2, d_rdata2;
  logic          ram_en2;
  logic [3:0]    ram_we2;
  logic [AW-1:0] ram_addr2;
  logic [DW-1:0] ram_wdata2, ram_rd2a, ram_rdata2;

  jedro_1_mem_arbiter #(.DATA_WIDTH(DW), .RAM_AW(AW), .RAM_LATENCY(2), .STARVE_MAX(3)) u_dut2 (
    .clk_i(clk), .rstn_i(rstn),
    .i_req_i(i_req2), .i_addr_i(i_addr2), .i_gnt_o(i_gnt2),
    .i_rvalid_o(i_rvalid2), .i_rdata_o(i_rdata2), .i_err_o(i_err2),
    .d_req_i(d_req2), .d_we_i(d_we2), .d_be_i(d_be2), .d_addr_i(d_addr2), .d_wdata_i(d_wdata2),
    .d_gnt_o(d_gnt2), .d_rvalid_o(d_rvalid2), .d_rdata_o(d_rdata2), .d_err_o(d_err2),
    .ram_en_o(ram_en2), .ram_we_o(ram_we2), .ram_addr_o(ram_addr2),
    .ram_wdata_o(ram_wdata2), .ram_rdata_i(ram_rdata2)
  );

  logic [DW-1:0] mem2 [4];
  always @(posedge clk) begin
    if (init_mem) begin
      mem2[0] <= 32'h1111_0000;
      mem2[1] <= 32'h2222_0001;
      mem2[2] <= 32'h3333_0002;
      mem2[3] <= 32'h0;
    end else if (ram_en2) begin
      ram_rd2a <= mem2[ram_addr2[1:0]];
    end
    ram_rdata2 <= ram_rd2a;
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp2_q[$];

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push1(input logic c, input logic sd, input logic er, input logic [DW-1:0] dat);
    exp_q.push_back({c, sd, er, dat, 16'(cyc + 1)});
  endtask

  // monitor DUT 1
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rstn && (i_rvalid || d_rvalid)) begin
      chk("rsp_one_hot", 32'(i_rvalid && d_rvalid), 32'd0);
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'(d_rvalid), 32'(i_rvalid));
      end else begin
        e = exp_q.pop_front();
        chk("rsp_cycle", 32'(cyc), 32'(e[15:0]));
        chk("rsp_src_d", 32'(d_rvalid), 32'(e[49]));
        chk("rsp_err", 32'(d_rvalid ? d_err : i_err), 32'(e[48]));
        if (e[50]) chk("rsp_data", d_rvalid ? d_rdata : i_rdata, e[47:16]);
        chk("rsp_other_rdata", d_rvalid ? i_rdata : d_rdata, 32'd0);
      end
    end
  end

  // monitor DUT 2
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rstn && (i_rvalid2 || d_rvalid2)) begin
      chk("lat2_no_fetch_rsp", 32'(i_rvalid2), 32'd0);
      if (exp2_q.size() == 0) begin
        chk("lat2_unexpected", 32'(d_rvalid2), 32'd0);
      end else begin
        e = exp2_q.pop_front();
        chk("lat2_cycle", 32'(cyc), 32'(e[15:0]));
        chk("lat2_err", 32'(d_err2), 32'(e[48]));
        chk("lat2_data", d_rdata2, e[47:16]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic ir, input logic [DW-1:0] ia, input logic dr, input logic dwe,
                       input logic [3:0] dbe, input logic [DW-1:0] da, input logic [DW-1:0] dw);
    @(posedge clk);
    #1;
    i_req = ir; i_addr = ia;
    d_req = dr; d_we = dwe; d_be = dbe; d_addr = da; d_wdata = dw;
    @(negedge clk);
  endtask

  // Check this cycle's request-side outputs and queue the expected response.
  task automatic exp_cycle(input logic eg_i, input logic eg_d, input logic e_en,
                           input logic [AW-1:0] e_addr, input logic [3:0] e_we,
                           input logic [DW-1:0] e_wd, input logic e_err,
                           input logic e_chk, input logic [DW-1:0] e_data);
    chk("i_gnt", 32'(i_gnt), 32'(eg_i));
    chk("d_gnt", 32'(d_gnt), 32'(eg_d));
    chk("ram_en", 32'(ram_en), 32'(e_en));
    chk("ram_addr", 32'(ram_addr), 32'(e_addr));
    chk("ram_we", 32'(ram_we), 32'(e_we));
    chk("ram_wdata", ram_wdata, e_wd);
    if (eg_i || eg_d) push1(e_chk, eg_d, e_err, e_data);
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, 4'h0, '0, '0);
    exp_cycle(1'b0, 1'b0, 1'b0, '0, 4'h0, '0, 1'b0, 1'b0, '0);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] cont_gi;
  logic [6:0] clr_ir;
  logic [6:0] clr_gi;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; init_mem = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h20; d_wdata = '0;
    i_req2 = 1'b0; i_addr2 = '0;
    d_req2 = 1'b0; d_we2 = 1'b0; d_be2 = 4'h0; d_addr2 = '0; d_wdata2 = '0;
    cont_gi = 8'b1000_1000;
    clr_ir  = 7'b111_1011;
    clr_gi  = 7'b100_0000;

    // reset state: request pending but nothing granted
    #3;
    chk("rst0_d_gnt", 32'(d_gnt), 32'd0);
    chk("rst0_ram_en", 32'(ram_en), 32'd0);
    chk("rst0_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("rst0_i_rvalid", 32'(i_rvalid), 32'd0);
    chk("rst0_d_rdata", d_rdata, 32'd0);
    d_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    init_mem = 1'b0;
    rstn = 1'b1;

    // single fetch
    drive(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, '0, '0);
    exp_cycle(1'b1, 1'b0, 1'b1, 12'h004, 4'h0, '0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    // partial store then loads of the same word
    drive(1'b0, '0, 1'b1, 1'b1, 4'b0011, 32'h20, 32'h1234_5678);
    exp_cycle(1'b0, 1'b1, 1'b1, 12'h008, 4'b0011, 32'h1234_5678, 1'b0, 1'b0, '0);
    drive(1'b0, '0, 1'b1, 1'b0, 4'h0, 32'h20, '0);
    exp_cycle(1'b0, 1'b1, 1'b1, 12'h008, 4'h0, '0, 1'b0, 1'b1, 32'h0000_5678);
    drive(1'b0, '0, 1'b1, 1'b0, 4'h0, 32'h23, '0);
    exp_cycle(1'b0, 1'b1, 1'b1, 12'h008, 4'h0, '0, 1'b0, 1'b1, 32'h0000_5678);
    // highest in-range word
    drive(1'b0, '0, 1'b1, 1'b0, 4'h0, 32'h3FFC, '0);
    exp_cycle(1'b0, 1'b1, 1'b1, 12'hFFF, 4'h0, '0, 1'b0, 1'b1, 32'hA5A5_0FF0);
    // error accesses
    drive(1'b1, 32'h2, 1'b0, 1'b0, 4'h0, '0, '0);
    exp_cycle(1'b1, 1'b0, 1'b0, '0, 4'h0, '0, 1'b1, 1'b1, '0);
    drive(1'b0, '0, 1'b1, 1'b0, 4'h0, 32'h4000, '0);
    exp_cycle(1'b0, 1'b1, 1'b0, '0, 4'h0, '0, 1'b1, 1'b1, '0);
    drive(1'b1, 32'h4000, 1'b0, 1'b0, 4'h0, '0, '0);
    exp_cycle(1'b1, 1'b0, 1'b0, '0, 4'h0, '0, 1'b1, 1'b1, '0);
    drive(1'b0, '0, 1'b1, 1'b1, 4'hF, 32'h8000, 32'hFFFF_FFFF);
    exp_cycle(1'b0, 1'b1, 1'b0, '0, 4'h0, '0, 1'b1, 1'b1, '0);
    idle();

    // contention: d,d,d,i,d,d,d,i
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 32'h10, 1'b1, 1'b0, 4'h0, 32'h20, '0);
      if (cont_gi[k]) exp_cycle(1'b1, 1'b0, 1'b1, 12'h004, 4'h0, '0, 1'b0, 1'b1, 32'hDEAD_BEEF);
      else            exp_cycle(1'b0, 1'b1, 1'b1, 12'h008, 4'h0, '0, 1'b0, 1'b1, 32'h0000_5678);
    end
    idle();

    // starve counter clears when the fetch request drops
    for (int k = 0; k < 7; k++) begin
      drive(clr_ir[k], 32'h10, 1'b1, 1'b0, 4'h0, 32'h20, '0);
      if (clr_gi[k]) exp_cycle(1'b1, 1'b0, 1'b1, 12'h004, 4'h0, '0, 1'b0, 1'b1, 32'hDEAD_BEEF);
      else           exp_cycle(1'b0, 1'b1, 1'b1, 12'h008, 4'h0, '0, 1'b0, 1'b1, 32'h0000_5678);
    end
    idle();

    // reset with a load in flight
    drive(1'b0, '0, 1'b1, 1'b0, 4'h0, 32'h20, '0);
    chk("rst_pre_gnt", 32'(d_gnt), 32'd1);
    @(posedge clk);
    #1;
    d_req = 1'b0;
    chk("rst_inflight_valid", 32'(d_rvalid), 32'd1);
    #1;
    rstn = 1'b0;
    d_req = 1'b1; i_req = 1'b1; i_addr = 32'h10;
    #1;
    chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_i_rvalid", 32'(i_rvalid), 32'd0);
    chk("rst_d_gnt", 32'(d_gnt), 32'd0);
    chk("rst_i_gnt", 32'(i_gnt), 32'd0);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_rvalid", 32'(d_rvalid), 32'd0);
    // grant in the very first cycle out of reset
    rstn = 1'b1;
    i_req = 1'b0;
    @(negedge clk);
    exp_cycle(1'b0, 1'b1, 1'b1, 12'h008, 4'h0, '0, 1'b0, 1'b1, 32'h0000_5678);
    idle();
    idle();

    // RAM_LATENCY = 2: back-to-back loads to words 0,1,2
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      d_req2 = 1'b1; d_addr2 = 32'(4 * k);
      @(negedge clk);
      chk("lat2_gnt", 32'(d_gnt2), 32'd1);
      chk("lat2_ram_addr", 32'(ram_addr2), 32'(k));
      exp2_q.push_back({1'b1, 1'b1, 1'b0,
                        (k == 0) ? 32'h1111_0000 : (k == 1) ? 32'h2222_0001 : 32'h3333_0002,
                        16'(cyc + 2)});
    end
    @(posedge clk);
    #1;
    d_req2 = 1'b0;

    // drain
    for (int t = 0; t < 20 && (exp_q.size() != 0 || exp2_q.size() != 0); t++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("drain_q1", 32'(exp_q.size()), 32'd0);
    chk("drain_q2", 32'(exp2_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
